// File: rtl/food_score_tracker.sv
// Live pellet map, pellet count and 4-digit BCD score for the maze game.
// Loads pellets from the maze ROM, eats the pellet under pacman on game ticks, serves rows to the renderer.
module food_score_tracker #(
  parameter int MAP_ROWS   = 50,
  parameter int MAP_COLS   = 80,
  parameter int TILE_SHIFT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                restart,
  input  logic                tick,
  input  logic [10:0]         pacman_pos_x,
  input  logic [9:0]          pacman_pos_y,
  output logic [5:0]          map_rd_y,
  input  logic [MAP_COLS-1:0] map_row,
  input  logic [5:0]          food_rd_y,
  output logic [MAP_COLS-1:0] food_row,
  output logic [15:0]         score,
  output logic [11:0]         food_left,
  output logic                eat_pulse,
  output logic                level_clear,
  output logic                busy
);

  localparam int ROW_W = $clog2(MAP_ROWS);
  localparam int COL_W = $clog2(MAP_COLS);
  localparam int PC_W  = $clog2(MAP_COLS + 1);
  localparam int TX_W  = 12 - TILE_SHIFT;
  localparam int TY_W  = 11 - TILE_SHIFT;

  localparam logic [5:0]      ROWS_6   = 6'(MAP_ROWS);
  localparam logic [5:0]      LAST_ROW = 6'(MAP_ROWS - 1);
  localparam logic [TX_W-1:0] COLS_TX  = TX_W'(MAP_COLS);
  localparam logic [TY_W-1:0] ROWS_TY  = TY_W'(MAP_ROWS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_IDLE,
    S_CHECK,
    S_EAT
  } state_t;

  state_t state_q, state_d;

  logic [MAP_COLS-1:0] food [MAP_ROWS];
  logic [5:0]          ld_cnt;
  logic [5:0]          wr_row;
  logic [TX_W-1:0]     tx_q, tile_x;
  logic [TY_W-1:0]     ty_q, tile_y;
  logic [11:0]         centre_x;
  logic [10:0]         centre_y;
  logic                hit_q;
  logic                in_range;
  logic                do_load_wr;
  logic                do_eat;

  function automatic logic [PC_W-1:0] popcount(input logic [MAP_COLS-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAP_COLS; i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  // Ripple a +1 through the BCD digits; a full 9999 score is held rather than wrapped.
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = (s != 16'h9999);
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (r[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != S_IDLE);
    map_rd_y   = (ld_cnt > LAST_ROW) ? LAST_ROW : ld_cnt;
    wr_row     = ld_cnt - 6'd1;
    centre_x   = {1'b0, pacman_pos_x} + 12'd8;
    centre_y   = {1'b0, pacman_pos_y} + 11'd8;
    tile_x     = centre_x[11:TILE_SHIFT];
    tile_y     = centre_y[10:TILE_SHIFT];
    in_range   = (tx_q < COLS_TX) && (ty_q < ROWS_TY);
    do_load_wr = !restart && (state_q == S_LOAD) && (ld_cnt != 6'd0);
    do_eat     = !restart && (state_q == S_EAT) && hit_q;
    if (restart) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (ld_cnt == ROWS_6) state_d = S_IDLE;
        S_IDLE:  if (tick) state_d = S_CHECK;
        S_CHECK: state_d = S_EAT;
        S_EAT:   state_d = S_IDLE;
        default: state_d = S_LOAD;
      endcase
    end
  end

  // The ROM answers one cycle late, so load counter value n writes row n-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      ld_cnt      <= 6'd0;
      tx_q        <= '0;
      ty_q        <= '0;
      hit_q       <= 1'b0;
      score       <= 16'h0000;
      food_left   <= 12'd0;
      eat_pulse   <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      state_q     <= state_d;
      eat_pulse   <= do_eat;
      level_clear <= !restart && (state_q == S_IDLE) && (food_left == 12'd0);
      if (restart) begin
        ld_cnt    <= 6'd0;
        food_left <= 12'd0;
      end else if (state_q == S_LOAD) begin
        if (ld_cnt != ROWS_6) ld_cnt <= ld_cnt + 6'd1;
        if (do_load_wr) food_left <= food_left + 12'(popcount(map_row));
      end else if (do_eat) begin
        food_left <= food_left - 12'd1;
        score     <= bcd_inc(score);
      end
      if ((state_q == S_IDLE) && tick) begin
        tx_q <= tile_x;
        ty_q <= tile_y;
      end
      if (state_q == S_CHECK) begin
        hit_q <= in_range && food[ty_q[ROW_W-1:0]][tx_q[COL_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < MAP_ROWS; r++) food[r] <= '0;
    end else if (do_load_wr) begin
      food[wr_row[ROW_W-1:0]] <= map_row;
    end else if (do_eat) begin
      food[ty_q[ROW_W-1:0]][tx_q[COL_W-1:0]] <= 1'b0;
    end
  end

  // Scan-out port sees the array before any same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      food_row <= '0;
    end else if (food_rd_y < ROWS_6) begin
      food_row <= food[food_rd_y[ROW_W-1:0]];
    end else begin
      food_row <= '0;
    end
  end

endmodule
